uart_pixel_tx: RTL and testbench
================================

Name: uart_pixel_tx

Overview:
Parametrised UART pixel serializer and the successor to the fixed 8N1 transmitter inside top. It buffers multi-byte pixels in an internal FIFO and transmits each pixel byte by byte. Line format is configurable: parity, stop-bit count and byte order. It asserts done after the last stop bit of a frame-tagged pixel and sits between the image-effect datapath and the board TX pin.

Parameters:
BPP, 3, bytes per pixel (1..4); pixel width SZ+1 = 8*BPP
FIFO_DEPTH, 16, pixel entries in the buffer; power of two, 2..256
TICK_PER_HALF, 2604, clocks per half bit; bit period = 2*TICK_PER_HALF clocks
PARITY, 0, parity mode: 0 none, 1 even, 2 odd
STOP_BITS, 1, stop bits per byte: 1 or 2
MSB_BYTE_FIRST, 1, 1 sends pix_data[SZ:SZ-7] first; 0 sends [7:0] first

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
pix_valid  in  1  pixel offered
pix_last  in  1  offered pixel ends the frame
pix_data  in  8*BPP  pixel word
pix_ready  out  1  FIFO can accept; transfer happens when pix_valid & pix_ready at a clk edge
tx  out  1  serial line, idle high
tx_active  out  1  high from the first start bit through the last stop bit of a busy period
done  out  1  one-clock pulse after the last stop bit of a pix_last pixel
fifo_count  out  clog2(FIFO_DEPTH)+1  entries currently buffered

Behaviour:
- Reset (rst=0, asynchronous), all outputs: tx=1, tx_active=0, done=0, fifo_count=0, pix_ready=1, FSM=IDLE, tick and bit counters=0, FIFO pointers=0. Reset mid-byte aborts immediately; the partial byte and all buffered pixels are discarded.
- FIFO: stores {last, data}. pix_ready = (fifo_count < FIFO_DEPTH), registered from count.
  - A simultaneous write and serializer read leaves the count unchanged.
  - When full, a write is refused even if a read occurs in the same cycle.
  - A read from an empty FIFO never happens.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LOAD, START, DATA, PAR, STOP.
  - IDLE: tx=1. If fifo_count>0, go to LOAD.
  - LOAD (1 clk): pop the pixel into the shift register, latch last, set byte_idx=0, go to START. tx_active rises on entry to START.
  - START: tx=0 for one bit period.
  - DATA: 8 bits, LSB first within the byte, one bit period each.
  - PAR: present only if PARITY!=0. Even: XOR of the 8 bits. Odd: its inverse.
  - STOP: tx=1 for STOP_BITS bit periods.
  - End of STOP, more bytes left: byte_idx+1, go to START with no idle gap.
  - End of STOP, last byte of pixel, FIFO non-empty: go to LOAD. The LOAD cycle holds tx=1, so it adds exactly 1 clock to the preceding stop bit.
  - End of STOP, last byte of pixel, FIFO empty: go to IDLE and drop tx_active in the same edge.
- Latency: a pixel accepted at edge N into an empty, idle block gives tx=0 from edge N+3 (IDLE sees count at N+1, LOAD at N+2, START drives at N+3).
- Byte order: MSB_BYTE_FIRST=1 sends byte BPP-1 first, down to byte 0.
- Frame length per byte = 1+8+(PARITY!=0)+STOP_BITS bits.
- done: pulses for 1 clk on the edge that leaves STOP of the final byte of a pixel whose last flag=1. It is independent of FIFO occupancy; a following frame may already be queued.
- Bit timing: tick counter runs 0..2*TICK_PER_HALF-1 and the bit advances on wrap. The counter resets to 0 when entering START from LOAD.
- Input changes during transmission never affect the byte in flight.

Test Plan:
- TICK_PER_HALF=2, BPP=3, PARITY=0, STOP_BITS=1; send one pixel 0xA1B2C3 with last=1 -> tx low 3 clks after accept; bytes 0xA1, 0xB2, 0xC3 each 0-bit, LSB-first data, 1-bit, 4 clks per bit; 120 clks tx_active; done pulses once at end.
- PARITY=1 then 2, byte 0x07 (BPP=1) -> parity bit 1 (even), 0 (odd); 11 bit periods per byte.
- FIFO_DEPTH=4: push 6 pixels back-to-back while transmitting -> pix_ready drops at fifo_count=4; no pixel lost or duplicated; output order equals input order; wrap of pointers exercised.
- Full FIFO with simultaneous pop and valid -> write refused that cycle, fifo_count goes 4→3, then the pixel is accepted next cycle.
- STOP_BITS=2, MSB_BYTE_FIRST=0, two frames queued (last on pixels 2 and 4) -> byte [7:0] sent first; stop high 8 clks (+1 at pixel boundary); done pulses twice; tx_active stays high throughout.
- Assert rst=0 mid-DATA -> tx=1, tx_active=0, fifo_count=0 asynchronously; after release, new pixel transmits cleanly with no residual bits.

Source files
------------

// File: rtl/uart_pixel_tx.sv
// UART pixel serializer: buffers {last, pixel} words in a FIFO and sends each
// pixel byte by byte with configurable parity, stop bits and byte order.
// tx, tx_active and done are registered. The line therefore follows the FSM
// state by one clock, while tx_active and done switch on the FSM edge itself.
module uart_pixel_tx #(
  parameter int BPP            = 3,
  parameter int FIFO_DEPTH     = 16,
  parameter int TICK_PER_HALF  = 2604,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int MSB_BYTE_FIRST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic                          pix_last,
  input  logic [8*BPP-1:0]              pix_data,
  output logic                          pix_ready,
  output logic                          tx,
  output logic                          tx_active,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SZ       = 8*BPP-1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int BIT_CLKS = 2*TICK_PER_HALF;
  localparam int TW       = $clog2(BIT_CLKS);
  localparam int BW       = (BPP > 1) ? $clog2(BPP) : 1;

  localparam logic [TW-1:0] TICK_MAX  = TW'(BIT_CLKS-1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BPP-1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS-1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  // FIFO storage and control
  logic [SZ+1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          wr_en;
  logic          rd_en;

  // Serializer state
  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [SZ:0]   pix_q, pix_d;
  logic          last_q, last_d;
  logic          tx_q, tx_d;
  logic          act_q, act_d;
  logic          done_q, done_d;

  logic [7:0]    cur_byte;
  logic          par_bit;
  logic          tick_wrap;

  // A full FIFO refuses writes even when the serializer pops in the same cycle,
  // because ready is a registered copy of the count.
  assign wr_en     = pix_valid & ready_q;
  assign tick_wrap = (tick_q == TICK_MAX);

  // FIFO pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
    ready_d  = (count_d < DEPTH_C);
  end

  // FIFO payload write; storage needs no reset since the pointers gate it
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {pix_last, pix_data};
  end

  // Select the byte in flight according to byte order, and its parity bit
  always_comb begin
    cur_byte = 8'h00;
    for (int i = 0; i < BPP; i++) begin
      if (byte_q == BW'(i)) begin
        if (MSB_BYTE_FIRST != 0) cur_byte = pix_q[8*(BPP-1-i) +: 8];
        else                     cur_byte = pix_q[8*i +: 8];
      end
    end
    par_bit = (^cur_byte) ^ (PARITY == 2);
  end

  // Serializer next-state, bit timing and line value
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pix_d   = pix_q;
    last_d  = last_q;
    rd_en   = 1'b0;
    done_d  = 1'b0;
    tx_d    = 1'b1;
    act_d   = act_q;
    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        rd_en   = 1'b1;
        {last_d, pix_d} = mem_q[rd_ptr_q];
        byte_d  = '0;
        tick_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        tx_d   = 1'b0;
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) begin
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_d   = cur_byte[bit_q];
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) begin
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PAR: begin
        tx_d   = par_bit;
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) begin
          bit_d   = 3'd0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        tx_d   = 1'b1;
        tick_d = tick_wrap ? '0 : tick_q + TW'(1);
        if (tick_wrap) begin
          if (bit_q != LAST_STOP) begin
            bit_d = bit_q + 3'd1;
          end else if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + BW'(1);
            state_d = S_START;
          end else begin
            done_d  = last_q;
            state_d = (count_q != '0) ? S_LOAD : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Active covers START..STOP; a LOAD between pixels keeps the current value
    case (state_d)
      S_IDLE:  act_d = 1'b0;
      S_LOAD:  act_d = act_q;
      default: act_d = 1'b1;
    endcase
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      state_q  <= S_IDLE;
      tick_q   <= '0;
      bit_q    <= 3'd0;
      byte_q   <= '0;
      last_q   <= 1'b0;
      tx_q     <= 1'b1;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      last_q   <= last_d;
      tx_q     <= tx_d;
      act_q    <= act_d;
      done_q   <= done_d;
    end
  end

  // Pixel holding register; only loaded in LOAD so input changes never disturb it
  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end

  assign pix_ready  = ready_q;
  assign tx         = tx_q;
  assign tx_active  = act_q;
  assign done       = done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_pixel_tx.sv
// Scoreboard bench for uart_pixel_tx: three configurations run one after the
// other; a line monitor decodes frames and checks them against queued bytes.
module tb_uart_pixel_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  pv;
  logic        pl;
  logic [23:0] pd;
  logic [2:0]  rdy_w, tx_w, act_w, done_w;
  logic [2:0]  fc0, fc1;
  logic [1:0]  fc2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int sel   = 0;
  bit mon_en = 1'b1;

  // Per-configuration line format (index = DUT instance)
  int bpp_c  [3] = '{3, 2, 1};
  int par_c  [3] = '{0, 2, 1};
  int stop_c [3] = '{1, 2, 1};
  int msb_c  [3] = '{1, 0, 1};

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         gap;
    logic       dn;
  } exp_t;
  exp_t sb[$];

  uart_pixel_tx #(.BPP(3), .FIFO_DEPTH(4), .TICK_PER_HALF(2), .PARITY(0),
                  .STOP_BITS(1), .MSB_BYTE_FIRST(1)) u0 (
    .clk(clk), .rst(rst), .pix_valid(pv[0]), .pix_last(pl), .pix_data(pd[23:0]),
    .pix_ready(rdy_w[0]), .tx(tx_w[0]), .tx_active(act_w[0]), .done(done_w[0]),
    .fifo_count(fc0));

  uart_pixel_tx #(.BPP(2), .FIFO_DEPTH(4), .TICK_PER_HALF(2), .PARITY(2),
                  .STOP_BITS(2), .MSB_BYTE_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .pix_valid(pv[1]), .pix_last(pl), .pix_data(pd[15:0]),
    .pix_ready(rdy_w[1]), .tx(tx_w[1]), .tx_active(act_w[1]), .done(done_w[1]),
    .fifo_count(fc1));

  uart_pixel_tx #(.BPP(1), .FIFO_DEPTH(2), .TICK_PER_HALF(2), .PARITY(1),
                  .STOP_BITS(1), .MSB_BYTE_FIRST(1)) u2 (
    .clk(clk), .rst(rst), .pix_valid(pv[2]), .pix_last(pl), .pix_data(pd[7:0]),
    .pix_ready(rdy_w[2]), .tx(tx_w[2]), .tx_active(act_w[2]), .done(done_w[2]),
    .fifo_count(fc2));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the bytes of one pixel in line order with their framing expectations
  task automatic expect_pixel(input int c, input logic [23:0] d, input logic last,
                              input bit queued);
    int   nb;
    int   fclk;
    int   idx;
    exp_t e;
    nb   = bpp_c[c];
    fclk = 4 * (9 + ((par_c[c] != 0) ? 1 : 0) + stop_c[c]);
    for (int i = 0; i < nb; i++) begin
      idx    = (msb_c[c] != 0) ? (nb - 1 - i) : i;
      e.data = d[8*idx +: 8];
      e.par  = (^e.data) ^ (par_c[c] == 2);
      e.gap  = (i > 0) ? fclk : (queued ? fclk + 1 : 0);
      e.dn   = last && (i == nb - 1);
      sb.push_back(e);
    end
  endtask

  // Offer one pixel to DUT c and hold it until it is accepted
  task automatic push(input int c, input logic [23:0] d, input logic last,
                      input bit queued, input bit track);
    int t;
    @(negedge clk);
    pd = d; pl = last; pv = 3'b000; pv[c] = 1'b1;
    t = 0;
    while (rdy_w[c] !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: pix_ready stayed 0x%0h, expected 0x1", rdy_w[c]);
    end else begin
      if (track) expect_pixel(c, d, last, queued);
      @(posedge clk);
    end
    #1 pv = 3'b000;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || act_w[sel] !== 1'b0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", sb.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  // Line monitor: decodes frames on the selected DUT at mid-bit and scores them
  initial begin : monitor
    logic [7:0] b;
    logic       p, st, s_ok, a_ok, dn;
    int         c, t0, prev;
    bit         have_prev;
    exp_t       e;
    have_prev = 1'b0;
    prev = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst === 1'b1 && tx_w[sel] === 1'b0) begin
        c  = sel;
        t0 = cyc;
        @(negedge clk);
        st   = tx_w[c];
        a_ok = act_w[c];
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx_w[c];
          a_ok &= act_w[c];
        end
        p = 1'b0;
        if (par_c[c] != 0) begin
          repeat (4) @(negedge clk);
          p = tx_w[c];
        end
        s_ok = 1'b1;
        for (int s = 0; s < stop_c[c]; s++) begin
          repeat (4) @(negedge clk);
          s_ok &= tx_w[c];
          a_ok &= act_w[c];
        end
        repeat (2) @(negedge clk);
        dn = done_w[c];
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no frame", b);
        end else begin
          e = sb.pop_front();
          chk("start_bit", st, 1'b0);
          chk("data_byte", b, e.data);
          if (par_c[c] != 0) chk("parity_bit", p, e.par);
          chk("stop_bits", s_ok, 1'b1);
          chk("active_in_frame", a_ok, 1'b1);
          chk("done_pulse", dn, e.dn);
          if (e.gap != 0 && have_prev) chk("start_gap", t0 - prev, e.gap);
        end
        prev = t0;
        have_prev = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   t, on_act, dn_cnt, lows, seen;
    logic tx2, tx3;
    rst = 1'b1; pv = 3'b000; pl = 1'b0; pd = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx_w, 3'b111);
    chk("reset_active", act_w, 3'b000);
    chk("reset_done", done_w, 3'b000);
    chk("reset_ready", rdy_w, 3'b111);
    chk("reset_count0", fc0, 0);
    chk("reset_count1", fc1, 0);
    chk("reset_count2", fc2, 0);
    rst = 1'b1;

    // Single 24-bit pixel, 8N1, MSB byte first: latency, busy length, one done
    sel = 0;
    push(0, 24'hA1B2C3, 1'b1, 1'b0, 1'b1);
    on_act = 0; dn_cnt = 0; tx2 = 1'bx; tx3 = 1'bx;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 2) tx2 = tx_w[0];
      if (k == 3) tx3 = tx_w[0];
      on_act += int'(act_w[0]);
      dn_cnt += int'(done_w[0]);
    end
    chk("latency_idle_at_n2", tx2, 1'b1);
    chk("latency_start_at_n3", tx3, 1'b0);
    chk("active_clocks", on_act, 120);
    chk("done_count_single", dn_cnt, 1);
    drain();

    // Back-to-back pixels into a 4-deep FIFO, then a write against a full FIFO
    push(0, 24'h010203, 1'b0, 1'b0, 1'b1);
    push(0, 24'h111213, 1'b0, 1'b1, 1'b1);
    push(0, 24'h212223, 1'b1, 1'b1, 1'b1);
    push(0, 24'h313233, 1'b0, 1'b1, 1'b1);
    push(0, 24'h414243, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    pd = 24'h515253; pl = 1'b1; pv = 3'b001;
    chk("full_count", fc0, 4);
    chk("full_ready", rdy_w[0], 1'b0);
    t = 0;
    while (rdy_w[0] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("count_after_pop_while_full", fc0, 3);
    expect_pixel(0, 24'h515253, 1'b1, 1'b1);
    @(posedge clk);
    #1 pv = 3'b000;
    @(negedge clk);
    chk("count_after_refill", fc0, 4);
    drain();

    // Asynchronous reset in the middle of a data byte with a pixel buffered
    mon_en = 1'b0;
    push(0, 24'h00FF00, 1'b1, 1'b0, 1'b0);
    push(0, 24'h123456, 1'b1, 1'b1, 1'b0);
    repeat (22) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midbyte_reset_tx", tx_w[0], 1'b1);
    chk("midbyte_reset_active", act_w[0], 1'b0);
    chk("midbyte_reset_count", fc0, 0);
    chk("midbyte_reset_ready", rdy_w[0], 1'b1);
    chk("midbyte_reset_done", done_w[0], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    lows = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      lows += int'(!tx_w[0]);
    end
    chk("idle_after_reset", lows, 0);
    chk("count_after_reset", fc0, 0);
    mon_en = 1'b1;
    push(0, 24'h5A3C96, 1'b1, 1'b0, 1'b1);
    drain();

    // Two queued frames: odd parity, 2 stop bits, LSB byte first
    sel = 1;
    push(1, 24'h001207, 1'b0, 1'b0, 1'b1);
    push(1, 24'h005678, 1'b1, 1'b1, 1'b1);
    push(1, 24'h009ABC, 1'b0, 1'b1, 1'b1);
    push(1, 24'h00DEF0, 1'b1, 1'b1, 1'b1);
    t = 0;
    while (act_w[1] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    lows = 0; seen = 0; t = 0;
    while (seen < 2 && t < 2000) begin
      @(negedge clk);
      if (done_w[1] === 1'b1) seen++;
      else if (act_w[1] !== 1'b1) lows++;
      t++;
    end
    chk("active_gapless_two_frames", lows, 0);
    chk("done_count_two_frames", seen, 2);
    drain();

    // Single-byte pixels with even parity through a 2-deep FIFO
    sel = 2;
    push(2, 24'h000007, 1'b1, 1'b0, 1'b1);
    push(2, 24'h000080, 1'b0, 1'b1, 1'b1);
    push(2, 24'h0000FF, 1'b1, 1'b1, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
